// File: rtl/vga_pkg.sv
// Frame geometry and writer FSM state shared by the VGA frame-buffer reader and writer,
// so both sides derive the same RAM depth and wrap point.
package vga_pkg;
    localparam int FRAME_W    = 480;
    localparam int FRAME_H    = 360;
    localparam int PIXEL_BITS = 24;
    localparam int FRAME_BITS = FRAME_W * FRAME_H * PIXEL_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } writer_state_t;
endpackage

// File: rtl/ram_writer_if.sv
// Byte-in / RAM-write-out bundle of the frame-buffer writer; master drives bytes, slave drives the RAM port.
// No backpressure: rx_ready is a strobe and the RAM accepts every write pulse.
interface ram_writer_if #(
    parameter int ADRESS_BITS = 17,
    parameter int RAM_WIDTH   = 32
);
    logic [7:0]             rx_data;
    logic                   rx_ready;
    logic                   clear;
    logic                   we;
    logic [ADRESS_BITS-1:0] adress;
    logic [RAM_WIDTH-1:0]   data_in;
    logic                   frame_done;

    modport master (
        output rx_data, rx_ready, clear,
        input  we, adress, data_in, frame_done
    );

    modport slave (
        input  rx_data, rx_ready, clear,
        output we, adress, data_in, frame_done
    );
endinterface

// File: rtl/ram_writer_byte_packer.sv
// Packs bytes MSB-first into a RAM word; word_vld/word_dat are combinational on the completing byte.
// No backpressure: every unblocked byte strobe is taken; clear or flush drop the partial word.
module byte_packer #(
    parameter int RAM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 flush,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_dat,
    output logic                 word_vld,
    output logic [RAM_WIDTH-1:0] word_dat
);
    localparam int BYTES_PER_WORD = RAM_WIDTH / 8;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    // Keep at least one byte of shift so single-byte words still elaborate.
    localparam int SW             = (RAM_WIDTH > 8) ? RAM_WIDTH - 8 : 8;

    logic [SW-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [SW+7:0]    word_full;
    logic             take;
    logic             last_byte;

    assign take      = byte_vld && !clear;
    assign last_byte = (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_full = {shift_q, byte_dat};
    assign word_vld  = take && last_byte;
    assign word_dat  = word_full[RAM_WIDTH-1:0];

    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        if (clear || flush) begin
            byte_cnt_d = '0;
        end else if (take) begin
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + CNT_W'(1);
        end
        if (take) begin
            shift_d = word_full[SW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
endmodule

// File: rtl/ram_writer.sv
// Frame-buffer writer: packs UART bytes into RAM words at a wrapping address; a write follows the completing byte by one cycle.
// No backpressure; a stalled partial word is discarded after TIMEOUT_CYCLES idle clocks.
module ram_writer
    import vga_pkg::*;
#(
    parameter int RAM_WIDTH      = 32,
    parameter int N_BITS         = FRAME_BITS,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_writer_if.slave  bus
);
    localparam int RAM_DEPTH   = N_BITS / RAM_WIDTH;
    localparam int MAX_ADRESS  = RAM_DEPTH - 1;
    localparam int ADRESS_BITS = $clog2(RAM_DEPTH);
    localparam int IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);

    writer_state_t          state_q, state_d;
    logic                   we_q, we_d;
    logic                   frame_done_q, frame_done_d;
    logic [RAM_WIDTH-1:0]   data_in_q, data_in_d;
    logic [ADRESS_BITS-1:0] adress_q, adress_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                   timeout;
    logic                   word_vld;
    logic [RAM_WIDTH-1:0]   word_dat;

    assign timeout = !bus.clear && (state_q == FILL) && !bus.rx_ready &&
                     (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    byte_packer #(.RAM_WIDTH(RAM_WIDTH)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .flush    (timeout),
        .byte_vld (bus.rx_ready),
        .byte_dat (bus.rx_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d      = state_q;
        adress_d     = adress_q;
        data_in_d    = data_in_q;
        idle_cnt_d   = idle_cnt_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        if (bus.clear) begin
            state_d    = IDLE;
            adress_d   = '0;
            idle_cnt_d = '0;
        end else begin
            if (we_q) begin
                adress_d = (adress_q == ADRESS_BITS'(MAX_ADRESS)) ? '0 : adress_q + ADRESS_BITS'(1);
            end
            case (state_q)
                IDLE: begin
                    if (bus.rx_ready) begin
                        idle_cnt_d = '0;
                        state_d    = word_vld ? IDLE : FILL;
                    end
                end
                FILL: begin
                    if (bus.rx_ready) begin
                        idle_cnt_d = '0;
                        if (word_vld) state_d = IDLE;
                    end else if (timeout) begin
                        idle_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // adress_d is the address presented during the write cycle.
            if (word_vld) begin
                we_d         = 1'b1;
                data_in_d    = word_dat;
                frame_done_d = (adress_d == ADRESS_BITS'(MAX_ADRESS));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            data_in_q    <= '0;
            adress_q     <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            data_in_q    <= data_in_d;
            adress_q     <= adress_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_in    = data_in_q;
    assign bus.adress     = adress_q;
endmodule

// File: tb/tb_ram_writer.sv
// Scoreboard bench: dut_a uses the full frame depth, dut_b a 4-word frame; both see identical byte streams.
module tb_ram_writer;
    import vga_pkg::*;

    localparam int A_AW = $clog2(FRAME_BITS / 32);
    localparam int B_AW = 2;

    typedef struct {
        int          adr;
        logic [31:0] dat;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_writer_if #(.ADRESS_BITS(A_AW), .RAM_WIDTH(32)) ifa ();
    ram_writer_if #(.ADRESS_BITS(B_AW), .RAM_WIDTH(32)) ifb ();

    ram_writer #(.RAM_WIDTH(32), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    ram_writer #(.RAM_WIDTH(32), .N_BITS(128), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   last_cyc_a = 0;
    int   prev_cyc_a = 0;
    int   fd_cnt_a = 0;
    int   fd_cnt_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.frame_done) begin
            fd_cnt_a++;
            check("a_fd_needs_we", 64'(ifa.we), 64'd1);
        end
        if (ifa.we) begin
            prev_cyc_a = last_cyc_a;
            last_cyc_a = cyc;
            if (qa.size() == 0) begin
                check("a_unexpected_write_adr", 64'(ifa.adress), 64'hFFFF_FFFF);
            end else begin
                ea = qa.pop_front();
                check("a_wr_adr", 64'(ifa.adress), 64'(ea.adr));
                check("a_wr_dat", 64'(ifa.data_in), 64'(ea.dat));
                check("a_wr_fd", 64'(ifa.frame_done), 64'(ea.fd));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.frame_done) begin
            fd_cnt_b++;
            check("b_fd_needs_we", 64'(ifb.we), 64'd1);
        end
        if (ifb.we) begin
            if (qb.size() == 0) begin
                check("b_unexpected_write_adr", 64'(ifb.adress), 64'hFFFF_FFFF);
            end else begin
                eb = qb.pop_front();
                check("b_wr_adr", 64'(ifb.adress), 64'(eb.adr));
                check("b_wr_dat", 64'(ifb.data_in), 64'(eb.dat));
                check("b_wr_fd", 64'(ifb.frame_done), 64'(eb.fd));
            end
        end
    end

    task automatic expect_both(input int adr_a, input int adr_b, input logic [31:0] dat, input logic fd_b);
        qa.push_back('{adr_a, dat, 1'b0});
        qb.push_back('{adr_b, dat, fd_b});
    endtask

    task automatic send(input logic [7:0] b);
        ifa.rx_ready = 1'b1; ifb.rx_ready = 1'b1;
        ifa.rx_data  = b;    ifb.rx_data  = b;
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        ifa.rx_ready = 1'b0; ifb.rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        ifa.clear = 1'b1; ifb.clear = 1'b1;
        @(posedge clk); #1;
        ifa.clear = 1'b0; ifb.clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d, expected done", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.rx_ready = 1'b0; ifa.rx_data = 8'h00; ifa.clear = 1'b0;
        ifb.rx_ready = 1'b0; ifb.rx_data = 8'h00; ifb.clear = 1'b0;

        // Reset state
        #12;
        check("rst_we", 64'(ifa.we), 64'd0);
        check("rst_fd", 64'(ifa.frame_done), 64'd0);
        check("rst_adr", 64'(ifa.adress), 64'd0);
        check("rst_dat", 64'(ifa.data_in), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word write
        expect_both(0, 0, 32'h11223344, 1'b0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); quiet();
        check("t1_we_now", 64'(ifa.we), 64'd1);
        check("t1_adr_during_we", 64'(ifa.adress), 64'd0);
        idle(1);
        check("t1_adr_after", 64'(ifa.adress), 64'd1);
        check("t1_we_dropped", 64'(ifa.we), 64'd0);

        // Back-to-back streaming
        expect_both(1, 1, 32'h01020304, 1'b0);
        expect_both(2, 2, 32'h05060708, 1'b0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        quiet();
        idle(1);
        check("t2_spacing", 64'(last_cyc_a - prev_cyc_a), 64'd4);
        check("t2_adr_b", 64'(ifb.adress), 64'd3);
        pulse_clear();
        check("clr_adr_a", 64'(ifa.adress), 64'd0);

        // Wrap on the 4-word frame
        expect_both(0, 0, 32'h10111213, 1'b0);
        expect_both(1, 1, 32'h14151617, 1'b0);
        expect_both(2, 2, 32'h18191A1B, 1'b0);
        expect_both(3, 3, 32'h1C1D1E1F, 1'b1);
        expect_both(4, 0, 32'h20212223, 1'b0);
        for (int i = 0; i < 20; i++) send(8'(8'h10 + i));
        quiet();
        idle(2);
        check("t3_fd_cnt_b", 64'(fd_cnt_b), 64'd1);
        check("t3_fd_cnt_a", 64'(fd_cnt_a), 64'd0);
        check("t3_adr_b_wrapped", 64'(ifb.adress), 64'd1);
        pulse_clear();

        // Timeout discards the stalled partial word
        expect_both(0, 0, 32'h01020304, 1'b0);
        send(8'hAA); send(8'hBB); quiet();
        idle(20);
        check("t4_state_idle", 64'(dut_a.state_q), 64'(IDLE));
        check("t4_adr_held", 64'(ifa.adress), 64'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); quiet();
        idle(2);
        pulse_clear();

        // Clear beats the completing byte
        expect_both(0, 0, 32'h01020304, 1'b0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06); send(8'h07);
        ifa.clear = 1'b1; ifb.clear = 1'b1;
        send(8'h08);
        ifa.clear = 1'b0; ifb.clear = 1'b0;
        quiet();
        check("t5_no_we", 64'(ifa.we), 64'd0);
        idle(3);
        check("t5_adr", 64'(ifa.adress), 64'd0);
        check("t5_state", 64'(dut_a.state_q), 64'(IDLE));
        expect_both(0, 0, 32'h0A0B0C0D, 1'b0);
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D); quiet();
        idle(2);

        // Asynchronous reset mid-word
        send(8'hEE); send(8'hFF); quiet();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we", 64'(ifa.we), 64'd0);
        check("t6_fd", 64'(ifa.frame_done), 64'd0);
        check("t6_adr", 64'(ifa.adress), 64'd0);
        check("t6_dat", 64'(ifa.data_in), 64'd0);
        check("t6_state", 64'(dut_a.state_q), 64'(IDLE));
        check("t6_byte_cnt", 64'(dut_a.u_packer.byte_cnt_q), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_both(0, 0, 32'h21222324, 1'b0);
        send(8'h21); send(8'h22); send(8'h23); send(8'h24); quiet();
        idle(3);

        check("drain_qa", 64'(qa.size()), 64'd0);
        check("drain_qb", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
